pipeline_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage core; consumes the forwarding unit's load-use Need_Stall plus EX redirects and memory busy flags.

---
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller for the 5-stage core: stage write-enable, flush and
// bubble control, stale-fetch tracking after redirects, perf counters and a freeze watchdog.
module pipeline_ctrl #(
  parameter int CNT_W      = 16,
  parameter int HANG_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             FU__Need_Stall,
  input  logic             EX__Branch_Taken,
  input  logic             EX__Jump,
  input  logic             IF__Busy,
  input  logic             MEM__Busy,
  output logic             PC_WE,
  output logic             IFid__WE,
  output logic             IFid__Flush,
  output logic             IDex__WE,
  output logic             IDex__Flush,
  output logic             EXmem__WE,
  output logic             EXmem__Bubble,
  output logic             MEMwb__WE,
  output logic [1:0]       Ctl_State,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic             Hang_Err
);

  localparam int FRZ_W = $clog2(HANG_LIMIT + 1);
  localparam logic [FRZ_W-1:0] FRZ_MAX = FRZ_W'(HANG_LIMIT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_LU_STALL = 2'b10,
    ST_REDIRECT = 2'b11
  } dec_e;

  dec_e             state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [FRZ_W-1:0] freeze_q, freeze_d;
  logic             hang_q, hang_d;
  logic             redirect;

  assign redirect = EX__Branch_Taken | EX__Jump;

  always_comb begin
    state_d       = ST_RUN;
    redir_pend_d  = redir_pend_q;
    PC_WE         = 1'b1;
    IFid__WE      = 1'b1;
    IFid__Flush   = 1'b0;
    IDex__WE      = 1'b1;
    IDex__Flush   = 1'b0;
    EXmem__WE     = 1'b1;
    EXmem__Bubble = 1'b0;
    MEMwb__WE     = 1'b1;
    if (rst) begin
      // Load NOPs into the front three registers; PC and WB hold.
      PC_WE         = 1'b0;
      MEMwb__WE     = 1'b0;
      IFid__Flush   = 1'b1;
      IDex__Flush   = 1'b1;
      EXmem__Bubble = 1'b1;
      redir_pend_d  = 1'b0;
    end else begin
      if (MEM__Busy) begin
        state_d   = ST_MEM_WAIT;
        PC_WE     = 1'b0;
        IFid__WE  = 1'b0;
        IDex__WE  = 1'b0;
        EXmem__WE = 1'b0;
        MEMwb__WE = 1'b0;
      end else if (FU__Need_Stall) begin
        state_d       = ST_LU_STALL;
        PC_WE         = 1'b0;
        IFid__WE      = 1'b0;
        IDex__WE      = 1'b0;
        EXmem__Bubble = 1'b1;
      end else if (redirect) begin
        state_d     = ST_REDIRECT;
        IFid__Flush = 1'b1;
        IDex__Flush = 1'b1;
      end else if (IF__Busy) begin
        PC_WE       = 1'b0;
        IFid__Flush = 1'b1;
      end
      // A fetch issued before the redirect may still be landing: drop it.
      if (redir_pend_q && IFid__WE) IFid__Flush = 1'b1;
      if (state_d != ST_MEM_WAIT) begin
        if (!IF__Busy)                  redir_pend_d = 1'b0;
        else if (state_d == ST_REDIRECT) redir_pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    freeze_d    = '0;
    if (!PC_WE && stall_cnt_q != '1)               stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (state_d == ST_REDIRECT && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (!MEMwb__WE) freeze_d = (freeze_q == FRZ_MAX) ? freeze_q : freeze_q + FRZ_W'(1);
    hang_d = hang_q | (freeze_d == FRZ_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_q     <= '0;
      hang_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_q     <= freeze_d;
      hang_q       <= hang_d;
    end
  end

  assign Ctl_State = state_q;
  assign Stall_Cnt = stall_cnt_q;
  assign Flush_Cnt = flush_cnt_q;
  assign Hang_Err  = hang_q;

endmodule
